// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift unit: operation codes, the FSM
// state encoding and a helper that classifies which op codes actually shift.
// Optional build macro used by the shift unit: FAST_SHIFT_EN.
package shift_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // NOP, LOAD and the reserved code never move bits, so they skip the shift loop
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_unit_seq_step.sv
// shift_step: combinational single-bit shift/rotate of a WIDTH-bit word.
// Ports:
//   op   - operation code (shift_pkg OP_*); non-shift codes pass din through
//   din  - word before the step
//   dout - word after one bit of the selected shift/rotate
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // One bit of movement per op; SRA replicates the sign bit, rotates wrap
  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
      OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
      OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
      OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
      OP_ROL:  dout = {din[WIDTH-2:0], din[WIDTH-1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multicycle shifter fed by the shamt select mux. A start
// pulse in IDLE captures op/shamt/data_in; shift ops then move one bit per
// cycle and the final word is committed to data_out together with done.
// Build option FAST_SHIFT_EN: replaces the serial loop with an unrolled
// barrel of shift_step stages so every op completes in one cycle.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   start    - one-cycle launch pulse (ignored unless IDLE)
//   op       - operation code, sampled on start
//   shamt    - shift amount, sampled on start
//   data_in  - operand, sampled on start
//   busy     - high while the serial shift loop is running
//   done     - one-cycle pulse when data_out holds the new result
//   data_out - result, held until the next operation completes
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  state_t           state_q, state_d;
  logic             commit;
  logic [WIDTH-1:0] commit_val;

`ifdef FAST_SHIFT_EN
  // Stage i holds data_in shifted by i bits; shamt then picks the stage
  logic [WIDTH-1:0] stage [0:WIDTH-1];

  assign stage[0] = data_in;

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_barrel
    shift_step #(.WIDTH(WIDTH)) u_step (
      .op  (op),
      .din (stage[i]),
      .dout(stage[i+1])
    );
  end

  // Every launch finishes in a single cycle; NOP and reserved leave data_out alone
  always_comb begin
    state_d    = state_q;
    commit     = 1'b0;
    commit_val = data_out;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DONE;
          if (op == OP_LOAD) begin
            commit     = 1'b1;
            commit_val = data_in;
          end else if (is_shift_op(op)) begin
            commit     = 1'b1;
            commit_val = stage[shamt];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and result commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      data_out <= '0;
    end else begin
      state_q <= state_d;
      if (commit) data_out <= commit_val;
    end
  end
`else
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op  (op_q),
    .din (work_q),
    .dout(step_out)
  );

  // Next-state logic. The result is committed on the edge that enters DONE,
  // so data_out changes exactly when done rises and never shows partial shifts.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    count_d    = count_q;
    op_d       = op_q;
    commit     = 1'b0;
    commit_val = data_out;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = data_in;
          count_d = shamt;
          op_d    = op;
          if (!is_shift_op(op)) begin
            state_d = ST_DONE;
            if (op == OP_LOAD) begin
              commit     = 1'b1;
              commit_val = data_in;
            end
          end else if (shamt == '0) begin
            state_d    = ST_DONE;
            commit     = 1'b1;
            commit_val = data_in;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d  = step_out;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d    = ST_DONE;
          commit     = 1'b1;
          commit_val = step_out;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, working register, step counter and result commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      count_q  <= '0;
      op_q     <= OP_NOP;
      data_out <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      op_q    <= op_d;
      if (commit) data_out <= commit_val;
    end
  end
`endif

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (serial build): directed vector
// table, hand-written multi-cycle sequences and randomized operations
// compared against an arithmetic reference model.
module tb_shift_unit_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_out;

  shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic [31:0] exp_out;
    int          exp_lat;
  } vec_t;

  // Reference result from plain shift/rotate arithmetic
  function automatic logic [31:0] model_result(input logic [2:0] o, input int s,
                                               input logic [31:0] d, input logic [31:0] prev);
    logic [63:0] dbl;
    dbl = {d, d};
    case (o)
      3'b001:  return d;
      3'b010:  return d << s;
      3'b011:  return d >> s;
      3'b100:  return 32'($signed(d) >>> s);
      3'b101:  return dbl[s +: 32];
      3'b110:  return dbl[(32 - s) % 32 +: 32];
      default: return prev;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] o, input int s);
    if (o >= 3'b010 && o <= 3'b110 && s > 0) return s + 1;
    return 1;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Launch one op, then watch busy/hold every cycle until done or timeout
  task automatic apply_stimulus(input string name, input logic [2:0] o, input logic [4:0] s,
                                input logic [31:0] d, input logic [31:0] exp_out,
                                input int exp_lat);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; data_in = d;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); shamt = 5'($urandom); data_in = $urandom;
    cyc = 1;
    while (!done && cyc <= 40) begin
      check_output({name, "_busy"}, 32'(busy), 32'd1);
      check_output({name, "_hold"}, data_out, last_out);
      @(negedge clk);
      cyc++;
    end
    check_output({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_output({name, "_data"}, data_out, exp_out);
    check_output({name, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check_output({name, "_done_one_cycle"}, 32'(done), 32'd0);
    last_out = exp_out;
  endtask

  initial begin
    vec_t vecs [$];
    int   cyc;
    logic saw_done;
    logic overwritten;

    reset = 1'b1; start = 1'b0; op = 3'd0; shamt = 5'd0; data_in = 32'd0;
    last_out = 32'd0;
    repeat (2) @(negedge clk);
    check_output("reset_data_out", data_out, 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Directed vectors with hand-computed results and latencies
    vecs.push_back('{3'b010, 5'd4,  32'h0000_0001, 32'h0000_0010, 5});
    vecs.push_back('{3'b100, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32});
    vecs.push_back('{3'b011, 5'd31, 32'h8000_0000, 32'h0000_0001, 32});
    vecs.push_back('{3'b101, 5'd4,  32'h0000_000F, 32'hF000_0000, 5});
    vecs.push_back('{3'b110, 5'd8,  32'hF000_0000, 32'h0000_00F0, 9});
    vecs.push_back('{3'b010, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1});
    vecs.push_back('{3'b001, 5'd9,  32'hCAFE_BABE, 32'hCAFE_BABE, 1});
    vecs.push_back('{3'b000, 5'd7,  32'h1234_0000, 32'hCAFE_BABE, 1});
    vecs.push_back('{3'b111, 5'd3,  32'h0000_5555, 32'hCAFE_BABE, 1});
    vecs.push_back('{3'b101, 5'd1,  32'h0000_0001, 32'h8000_0000, 2});
    vecs.push_back('{3'b110, 5'd31, 32'h0000_0001, 32'h8000_0000, 32});
    vecs.push_back('{3'b100, 5'd4,  32'h7000_0000, 32'h0700_0000, 5});
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].shamt, vecs[i].din,
                     vecs[i].exp_out, vecs[i].exp_lat);
    end

    // Reset in the middle of a long SRL: no done, result cleared
    apply_stimulus("pre_reset_load", 3'b001, 5'd0, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1);
    @(negedge clk);
    start = 1'b1; op = 3'b011; shamt = 5'd20; data_in = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("midreset_data_out", data_out, 32'd0);
    check_output("midreset_busy", 32'(busy), 32'd0);
    check_output("midreset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_output("midreset_no_done", 32'(saw_done), 32'd0);
    last_out = 32'd0;
    apply_stimulus("post_reset_load", 3'b001, 5'd0, 32'h1234_5678, 32'h1234_5678, 1);

    // start while busy and start coincident with done are both ignored
    @(negedge clk);
    start = 1'b1; op = 3'b011; shamt = 5'd10; data_in = 32'hF000_0000;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc <= 40) begin
      start = (cyc == 3);
      op = 3'b001; data_in = 32'h1111_1111;
      @(negedge clk);
      cyc++;
    end
    start = 1'b1; op = 3'b001; data_in = 32'h2222_2222;
    check_output("ignore_latency", 32'(cyc), 32'd11);
    check_output("ignore_data", data_out, 32'h003C_0000);
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    overwritten = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) saw_done = 1'b1;
      if (data_out !== 32'h003C_0000) overwritten = 1'b1;
      @(negedge clk);
    end
    check_output("ignore_no_extra_done", 32'(saw_done), 32'd0);
    check_output("ignore_no_overwrite", 32'(overwritten), 32'd0);
    last_out = 32'h003C_0000;

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [4:0]  rs;
      logic [31:0] rd;
      ro = 3'($urandom_range(0, 7));
      rs = 5'($urandom_range(0, 31));
      rd = $urandom;
      apply_stimulus($sformatf("rand%0d", i), ro, rs, rd,
                     model_result(ro, int'(rs), rd, last_out), model_latency(ro, int'(rs)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
Multicycle shift register that sits directly downstream of the shift-amount select mux. It takes the 5-bit shift amount and a 32-bit operand, then performs logical, arithmetic or rotate shifts one bit per cycle. It holds the result for write-back to the register bank. The control unit launches an operation with a start pulse and waits for done.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle launch pulse from control unit
op  input  3  operation code, sampled on start
shamt  input  SHAMT_W  shift amount from shamt select mux, sampled on start
data_in  input  WIDTH  operand, sampled on start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when data_out is final
data_out  output  WIDTH  shift result, held until the next operation completes

Behaviour:
- Reset (async, active-high): state=IDLE, data_out=0, busy=0, done=0, count=0.
- Op codes:
  - 000 NOP: no change; done pulses.
  - 001 LOAD: data_out=data_in.
  - 010 SLL: zero fill.
  - 011 SRL: zero fill.
  - 100 SRA: replicate bit WIDTH-1.
  - 101 ROR.
  - 110 ROL.
  - 111 reserved: treated as NOP.
- State IDLE:
  - start=1 captures data_in into the working register, loads count=shamt and latches op.
  - For op in {NOP, LOAD, reserved}, or when shamt==0: go to DONE.
  - Otherwise: go to SHIFT with busy=1.
- State SHIFT: each cycle applies a 1-bit step of the latched op to the working register and decrements count. When count reaches 1 (last step this cycle), go to DONE.
- State DONE:
  - data_out takes the working register; done=1 for exactly one cycle; busy=0.
  - Go to IDLE.
  - The working register is committed to data_out only in DONE. data_out never shows intermediate values.
- Latency from the start edge to the done pulse:
  - shamt+1 cycles for shift ops with shamt>0.
  - 1 cycle for LOAD, NOP or shamt==0.
- start while busy or in DONE: ignored. No queuing, and inputs are not resampled.
- shamt==31 SRA on 0x80000000 gives 0xFFFFFFFF. shamt==31 SRL gives 0x00000001.
- Rotates wrap bits; no bits are lost.
- Reset asserted mid-operation aborts immediately. There is no done pulse and data_out=0.
- done and start in the same cycle: the FSM is in DONE, so start is ignored; the control unit must re-issue.

Optional Feature:
FAST_SHIFT_EN
- Defined: SHIFT state is not compiled. A combinational barrel shifter computes the full result from the captured operands. IDLE goes straight to DONE, so latency is 1 cycle for every op and shamt. busy is never observed high on a clock edge.
- Undefined: serial behaviour as specified above.
- Result values are identical in both builds for all op/shamt/data_in combinations.

Decomposition:
- Shared package/header shift_pkg holds:
  - Op code constants: OP_NOP, OP_LOAD, OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL.
  - FSM state encoding: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- One sub-module, shift_step: combinational 1-bit shift of WIDTH bits per op. It is reused by the serial path and, unrolled, by the FAST_SHIFT_EN barrel path.

Test Plan:
- Reset check: reset pulse mid-SRL with shamt=20 at cycle 5 -> data_out=0, busy=0, no done; a following LOAD of 0x12345678 completes normally.
- SLL: start with data_in=0x00000001, op=SLL, shamt=4 -> done on cycle 5 after start, data_out=0x00000010, busy high for cycles 1-4.
- SRA sign fill: data_in=0x80000000, op=SRA, shamt=31 -> data_out=0xFFFFFFFF after 32 cycles. Same operand with SRL -> 0x00000001.
- Rotates: ROR with data_in=0x0000000F, shamt=4 -> 0xF0000000. ROL with 0xF0000000, shamt=8 -> 0x000000F0.
- Zero shift and LOAD: SLL with shamt=0 on 0xDEADBEEF -> data_out=0xDEADBEEF with done 1 cycle after start. LOAD of 0xCAFEBABE -> done 1 cycle after start.
- start ignored while busy: during an SRL with shamt=10, pulse start with LOAD 0x11111111 -> ignored. The SRL result is reported at cycle 11 and data_out is not overwritten afterwards.
